// File: rtl/uart_word_tx_fifo.sv
`default_nettype none
// ============================================================================
// uart_word_tx_fifo : queues multi-byte words and feeds them byte by byte to a
//                     byte-level UART transmitter.  Revision 1.0
// ============================================================================
module uart_word_tx_fifo #(
  parameter int         WORD_BYTES = 4,
  parameter int         DEPTH      = 4,
  parameter bit         TERM_EN    = 1'b0,
  parameter logic [7:0] TERM_BYTE  = 8'h0A,
  localparam int        WORD_W     = 8 * WORD_BYTES,
  localparam int        CW         = $clog2(WORD_BYTES + 1),
  localparam int        LW         = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic [CW-1:0]     in_bytes,
  input  logic              in_msb_first,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              busy,
  output logic [LW-1:0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_RAISE = 3'd3,
    S_HOLD  = 3'd4,
    S_WAIT  = 3'd5
  } state_t;

  // FIFO storage is never reset; occupancy is tracked by level_q
  logic [WORD_W-1:0] mem_word_q [DEPTH];
  logic [CW-1:0]     mem_cnt_q  [DEPTH];
  logic              mem_msb_q  [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [CW-1:0] in_cnt;
  logic          push, pop;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [CW-1:0]     rem_q, rem_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              msb_q, msb_d;
  logic              term_done_q, term_done_d;
  logic              is_term_q, is_term_d;
  logic [7:0]        byte_q, byte_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;

  always_comb begin
    in_cnt   = (in_bytes > CW'(WORD_BYTES)) ? CW'(WORD_BYTES) : in_bytes;
    in_ready = (level_q != LW'(DEPTH));
    push     = in_valid && in_ready;
    pop      = (state_q == S_LOAD);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_word_q[wr_ptr_q] <= in_word;
      mem_cnt_q[wr_ptr_q]  <= in_cnt;
      mem_msb_q[wr_ptr_q]  <= in_msb_first;
    end
  end

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    rem_d       = rem_q;
    idx_d       = idx_q;
    msb_d       = msb_q;
    term_done_d = term_done_q;
    is_term_d   = is_term_q;
    byte_d      = byte_q;
    tx_start_d  = tx_start_q;
    tx_data_d   = tx_data_q;
    case (state_q)
      S_IDLE: begin
        if (level_q != '0) state_d = S_LOAD;
      end
      S_LOAD: begin
        word_d      = mem_word_q[rd_ptr_q];
        rem_d       = mem_cnt_q[rd_ptr_q];
        msb_d       = mem_msb_q[rd_ptr_q];
        idx_d       = (mem_msb_q[rd_ptr_q] && mem_cnt_q[rd_ptr_q] != '0)
                      ? IW'(mem_cnt_q[rd_ptr_q] - 1'b1) : '0;
        term_done_d = 1'b0;
        state_d     = S_CHECK;
      end
      S_CHECK: begin
        if (rem_q != '0) begin
          byte_d    = word_q[8*idx_q +: 8];
          is_term_d = 1'b0;
          state_d   = S_RAISE;
        end else if (TERM_EN && !term_done_q) begin
          byte_d      = TERM_BYTE;
          is_term_d   = 1'b1;
          term_done_d = 1'b1;
          state_d     = S_RAISE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RAISE: begin
        tx_start_d = 1'b1;
        tx_data_d  = byte_q;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        if (tx_busy) begin
          tx_start_d = 1'b0;
          if (!is_term_q && rem_q != '0) begin
            rem_d = rem_q - 1'b1;
            // idx only moves while another payload byte remains, so it stays in range
            if (rem_q > CW'(1)) idx_d = msb_q ? idx_q - 1'b1 : idx_q + 1'b1;
          end
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!tx_busy) state_d = S_CHECK;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      state_q     <= S_IDLE;
      word_q      <= '0;
      rem_q       <= '0;
      idx_q       <= '0;
      msb_q       <= 1'b0;
      term_done_q <= 1'b0;
      is_term_q   <= 1'b0;
      byte_q      <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      state_q     <= state_d;
      word_q      <= word_d;
      rem_q       <= rem_d;
      idx_q       <= idx_d;
      msb_q       <= msb_d;
      term_done_q <= term_done_d;
      is_term_q   <= is_term_d;
      byte_q      <= byte_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign level    = level_q;
  assign busy     = (level_q != '0) || (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_word_tx_fifo.sv
`default_nettype none
// Bench for uart_word_tx_fifo: two instances (no terminator / with terminator),
// a busy-for-10-cycles transmitter model each, and a byte scoreboard.
module tb_uart_word_tx_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]       in_valid, in_ready, in_msb, tx_start, tx_busy, busy, force_busy;
  logic [1:0][31:0] in_word;
  logic [1:0][2:0]  in_bytes, level;
  logic [1:0][7:0]  tx_data;
  int               xcnt [2];

  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];
  int total = 0;
  int bad   = 0;

  uart_word_tx_fifo #(.WORD_BYTES(4), .DEPTH(4), .TERM_EN(1'b0), .TERM_BYTE(8'h0A)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_word(in_word[0]), .in_bytes(in_bytes[0]), .in_msb_first(in_msb[0]),
    .tx_start(tx_start[0]), .tx_data(tx_data[0]), .tx_busy(tx_busy[0]),
    .busy(busy[0]), .level(level[0]));

  uart_word_tx_fifo #(.WORD_BYTES(4), .DEPTH(4), .TERM_EN(1'b1), .TERM_BYTE(8'h0A)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_word(in_word[1]), .in_bytes(in_bytes[1]), .in_msb_first(in_msb[1]),
    .tx_start(tx_start[1]), .tx_data(tx_data[1]), .tx_busy(tx_busy[1]),
    .busy(busy[1]), .level(level[1]));

  // Byte transmitter: takes a start, stays busy 10 cycles; force_busy pins it busy.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) xcnt[d] = 0;
      else if (xcnt[d] != 0) xcnt[d] = xcnt[d] - 1;
      else if (tx_start[d] && !force_busy[d]) xcnt[d] = 10;
      tx_busy[d] = force_busy[d] || (xcnt[d] != 0);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h @%0t", name, got, req, $time);
    end
  endtask

  // Reference: bytes of a word in transmit order, then the terminator if enabled.
  function automatic void model_push(input int d, input logic [31:0] w, input int nb, input bit msb);
    int n;
    logic [31:0] t;
    n = (nb > 4) ? 4 : nb;
    for (int k = 0; k < n; k++) begin
      t = w >> (8 * (msb ? (n - 1 - k) : k));
      if (d == 0) exp0.push_back(t[7:0]); else exp1.push_back(t[7:0]);
    end
    if (d == 1) exp1.push_back(8'h0A);
  endfunction

  task automatic push(input int d, input logic [31:0] w, input int nb, input bit msb,
                      input bit retry, output bit acc);
    int tries = 0;
    acc = 1'b0;
    @(negedge clk);
    in_valid[d] = 1'b1; in_word[d] = w; in_bytes[d] = nb[2:0]; in_msb[d] = msb;
    forever begin
      if (in_ready[d]) begin
        acc = 1'b1;
        model_push(d, w, nb, msb);
      end
      @(posedge clk); #1;
      if (acc || !retry || tries >= 3000) break;
      tries++;
    end
    in_valid[d] = 1'b0;
    if (retry && !acc) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int limit);
    int c = 0;
    while ((busy != 2'b00 || exp0.size() != 0 || exp1.size() != 0) && c < limit) begin
      @(negedge clk); c++;
    end
    check("drain_busy", {30'd0, busy}, 32'd0);
    check("drain_q0", exp0.size(), 32'd0);
    check("drain_q1", exp1.size(), 32'd0);
  endtask

  task automatic monitor();
    logic [1:0]      prev_start = 2'b00;
    logic [1:0][7:0] prev_data  = '0;
    logic [7:0]      e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (tx_start[d] && !prev_start[d]) begin
          if ((d == 0 ? exp0.size() : exp1.size()) == 0) begin
            total++; bad++;
            $display("FAIL unexpected_start dut%0d got=%02h required=none @%0t", d, tx_data[d], $time);
          end else begin
            e = (d == 0) ? exp0.pop_front() : exp1.pop_front();
            check(d == 0 ? "tx_byte_dut0" : "tx_byte_dut1", {24'd0, tx_data[d]}, {24'd0, e});
          end
        end else if (tx_start[d] && prev_start[d]) begin
          check("tx_data_stable", {24'd0, tx_data[d]}, {24'd0, prev_data[d]});
        end
        prev_start[d] = tx_start[d];
        prev_data[d]  = tx_data[d];
      end
    end
  endtask

  initial begin
    bit acc;
    int c;
    rst = 1'b1;
    in_valid = '0; in_msb = '0; in_word = '0; in_bytes = '0; force_busy = '0;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_tx_start", {31'd0, tx_start[d]}, 32'd0);
      check("rst_tx_data",  {24'd0, tx_data[d]},  32'd0);
      check("rst_level",    {29'd0, level[d]},    32'd0);
      check("rst_in_ready", {31'd0, in_ready[d]}, 32'd1);
      check("rst_busy",     {31'd0, busy[d]},     32'd0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // LSB-first word plus start latency from the accepting edge
    push(0, 32'h44332211, 4, 1'b0, 1'b1, acc);
    repeat (3) @(posedge clk);
    #1 check("latency_e3", {31'd0, tx_start[0]}, 32'd0);
    @(posedge clk);
    #1 check("latency_e4", {31'd0, tx_start[0]}, 32'd1);
    drain(500);

    push(0, 32'h44332211, 3, 1'b1, 1'b1, acc);
    drain(500);

    // zero-length word without terminator is just consumed
    push(0, 32'h55667788, 0, 1'b0, 1'b1, acc);
    check("zero_level1", {29'd0, level[0]}, 32'd1);
    repeat (4) @(posedge clk);
    #1 check("zero_level0", {29'd0, level[0]}, 32'd0);
    check("zero_busy", {31'd0, busy[0]}, 32'd0);

    push(0, 32'hA1B2C3D4, 7, 1'b0, 1'b1, acc);
    drain(500);

    push(1, 32'h0000BEEF, 2, 1'b0, 1'b1, acc);
    push(1, 32'h12345678, 0, 1'b1, 1'b1, acc);
    drain(800);

    // transmitter pinned busy: start pulse is one cycle, FIFO fills to DEPTH
    force_busy[0] = 1'b1;
    push(0, 32'h0D0C0B0A, 4, 1'b0, 1'b1, acc);
    c = 0;
    while (!tx_start[0] && c < 20) begin @(negedge clk); c++; end
    check("forced_start_seen", {31'd0, tx_start[0]}, 32'd1);
    @(negedge clk);
    check("forced_start_1cyc", {31'd0, tx_start[0]}, 32'd0);
    repeat (4) @(negedge clk);
    check("forced_level0", {29'd0, level[0]}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      push(0, 32'h10203040 + i, 2, i[0], 1'b0, acc);
      check("fill_accept", {31'd0, acc}, 32'd1);
    end
    check("full_level", {29'd0, level[0]}, 32'd4);
    check("full_in_ready", {31'd0, in_ready[0]}, 32'd0);
    push(0, 32'hCAFEF00D, 4, 1'b1, 1'b0, acc);
    check("full_reject", {31'd0, acc}, 32'd0);
    force_busy[0] = 1'b0;
    push(0, 32'hCAFEF00D, 4, 1'b1, 1'b1, acc);
    drain(3000);

    // reset while a byte is in HOLD with two words still queued
    for (int i = 0; i < 3; i++) push(0, 32'h99887766 + i, 4, 1'b0, 1'b1, acc);
    c = 0;
    while (!(tx_start[0] && level[0] == 3'd2) && c < 100) begin @(negedge clk); c++; end
    check("hold_reached", {31'd0, tx_start[0]}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("midrst_tx_start", {31'd0, tx_start[0]}, 32'd0);
    check("midrst_level",    {29'd0, level[0]},    32'd0);
    check("midrst_in_ready", {31'd0, in_ready[0]}, 32'd1);
    exp0.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("postrst_busy", {31'd0, busy[0]}, 32'd0);

    // randomized traffic on both instances concurrently
    fork
      begin
        bit a0;
        for (int i = 0; i < 25; i++) begin
          push(0, $urandom, $urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'b1, a0);
          repeat ($urandom_range(0, 6)) @(negedge clk);
        end
      end
      begin
        bit a1;
        for (int i = 0; i < 25; i++) begin
          push(1, $urandom, $urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'b1, a1);
          repeat ($urandom_range(0, 6)) @(negedge clk);
        end
      end
    join
    drain(20000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
